// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
// Holds the control-word field widths, the result_src encodings and the
// bubble constant (the all-zero control word loaded on a flush).
package id_ex_stage_pkg;

  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned IMM_SRC_W  = 2;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  // Control word carried from D to E. The valid bit travels with it so a
  // bubble is simply this struct cleared.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic                  result_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection for the ID/EX stage (module hazard_load_use).
// Purely combinational.
// Inputs : valid_e, result_src_e, rd_e  - registered state of the E slot
//          rs1_d, rs2_d, valid_d        - source indices / validity in D
//          pc_src_e                     - branch taken in EX this cycle
// Outputs: lw_stall                     - raw load-use detection
//          stall_f, stall_d             - hold PC and IF/ID
//          flush_e                      - load a bubble into E next edge
module hazard_load_use
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              valid_e,
  input  logic              result_src_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              valid_d,
  input  logic              pc_src_e,
  output logic              lw_stall,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e
);

  logic rd_hit;

  // rs2 is compared even for I-type instructions; the spurious stall is harmless.
  assign rd_hit   = (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign lw_stall = valid_e && (result_src_e == RES_MEM) && rd_hit;

  // A taken branch redirects fetch, so holding IF/ID would be wrong.
  assign stall_f  = lw_stall && !pc_src_e;
  assign stall_d  = stall_f;

  assign flush_e  = lw_stall || pc_src_e || !valid_d;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Registers the control word and decode operands into EX with one cycle of
// latency, inserting a bubble on load-use hazards, taken branches or an
// empty decode slot. The E register always advances; stalls act upstream.
// Ports: clk/rst (synchronous, active-high); *_d decode-side control word,
// operands and indices; pc_src_e branch taken; stall_f/stall_d hazard
// stalls; *_e registered EX-side outputs.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d,
  input  logic                  reg_write_d,
  input  logic                  mem_write_d,
  input  logic                  branch_d,
  input  logic                  alu_src_d,
  input  logic                  result_src_d,
  input  logic [ALU_CTRL_W-1:0] alu_control_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_ext_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       pc_plus4_d,
  input  logic [REG_AW-1:0]     rs1_d,
  input  logic [REG_AW-1:0]     rs2_d,
  input  logic [REG_AW-1:0]     rd_d,
  input  logic                  pc_src_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  branch_e,
  output logic                  alu_src_e,
  output logic                  result_src_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       pc_plus4_e,
  output logic [REG_AW-1:0]     rs1_e,
  output logic [REG_AW-1:0]     rs2_e,
  output logic [REG_AW-1:0]     rd_e
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]   rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
  logic              flush_e;
  logic              unused_lw_stall;

  hazard_load_use #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .valid_e     (ctrl_q.valid),
    .result_src_e(ctrl_q.result_src),
    .rd_e        (rd_q),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .valid_d     (valid_d),
    .pc_src_e    (pc_src_e),
    .lw_stall    (unused_lw_stall),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_e     (flush_e)
  );

  always_comb begin
    ctrl_in             = CTRL_BUBBLE;
    ctrl_in.valid       = 1'b1;
    ctrl_in.reg_write   = reg_write_d;
    ctrl_in.mem_write   = mem_write_d;
    ctrl_in.branch      = branch_d;
    ctrl_in.alu_src     = alu_src_d;
    ctrl_in.result_src  = result_src_d;
    ctrl_in.alu_control = alu_control_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= CTRL_BUBBLE;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      pc_plus4_q  <= '0;
    end else begin
      // rd is cleared on a bubble so the cleared slot can never match a source.
      if (flush_e) begin
        ctrl_q <= CTRL_BUBBLE;
        rd_q   <= '0;
      end else begin
        ctrl_q <= ctrl_in;
        rd_q   <= rd_d;
      end
      // Datapath fields are don't-care in a bubble, so they always capture.
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_ext_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_e       = ctrl_q.valid;
  assign reg_write_e   = ctrl_q.reg_write;
  assign mem_write_e   = ctrl_q.mem_write;
  assign branch_e      = ctrl_q.branch;
  assign alu_src_e     = ctrl_q.alu_src;
  assign result_src_e  = ctrl_q.result_src;
  assign alu_control_e = ctrl_q.alu_control;
  assign rd_e          = rd_q;
  assign rs1_e         = rs1_q;
  assign rs2_e         = rs2_q;
  assign rd1_e         = rd1_q;
  assign rd2_e         = rd2_q;
  assign imm_ext_e     = imm_q;
  assign pc_e          = pc_q;
  assign pc_plus4_e    = pc_plus4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against an instruction-level model of the E slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d, reg_write_d, mem_write_d, branch_d, alu_src_d, result_src_d;
  logic [2:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        pc_src_e;
  logic        stall_f, stall_d;
  logic        valid_e, reg_write_e, mem_write_e, branch_e, alu_src_e, result_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int total = 0;
  int bad   = 0;

  // Model of the instruction sitting in EX: either a real instruction or empty.
  bit          m_known = 0;
  bit          m_full;
  bit          m_is_load;
  bit          m_rw, m_mw, m_br, m_as;
  logic [2:0]  m_alu;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rs1, m_rs2, m_rd;

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_d      (valid_d),
    .reg_write_d  (reg_write_d),
    .mem_write_d  (mem_write_d),
    .branch_d     (branch_d),
    .alu_src_d    (alu_src_d),
    .result_src_d (result_src_d),
    .alu_control_d(alu_control_d),
    .rd1_d        (rd1_d),
    .rd2_d        (rd2_d),
    .imm_ext_d    (imm_ext_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .pc_src_e     (pc_src_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .valid_e      (valid_e),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .branch_e     (branch_e),
    .alu_src_e    (alu_src_e),
    .result_src_e (result_src_e),
    .alu_control_e(alu_control_e),
    .rd1_e        (rd1_e),
    .rd2_e        (rd2_e),
    .imm_ext_e    (imm_ext_e),
    .pc_e         (pc_e),
    .pc_plus4_e   (pc_plus4_e),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_d();
    valid_d = 1'b0; reg_write_d = 1'b0; mem_write_d = 1'b0; branch_d = 1'b0;
    alu_src_d = 1'b0; result_src_d = 1'b0; alu_control_d = 3'd0;
    rd1_d = '0; rd2_d = '0; imm_ext_d = '0; pc_d = '0; pc_plus4_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; pc_src_e = 1'b0;
  endtask

  task automatic rand_d();
    valid_d       = ($urandom_range(9) != 0);
    reg_write_d   = 1'($urandom);
    mem_write_d   = 1'($urandom);
    branch_d      = 1'($urandom);
    alu_src_d     = 1'($urandom);
    result_src_d  = 1'($urandom);
    alu_control_d = 3'($urandom);
    rd1_d         = $urandom;
    rd2_d         = $urandom;
    imm_ext_d     = $urandom;
    pc_d          = $urandom & 32'hffff_fffc;
    pc_plus4_d    = pc_d + 32'd4;
    rs1_d         = 5'($urandom_range(7));
    rs2_d         = 5'($urandom_range(7));
    rd_d          = 5'($urandom_range(7));
    pc_src_e      = ($urandom_range(6) == 0);
  endtask

  // One clock: check the stall outputs for the current D inputs, take the
  // edge, advance the model, then check every E output the model defines.
  task automatic cycle();
    bit hazard, exp_stall, bubble;
    #1;
    hazard    = m_full && m_is_load && (m_rd != 0) && (m_rd == rs1_d || m_rd == rs2_d);
    exp_stall = hazard && !pc_src_e;
    if (m_known) begin
      chk("stall_f", 32'(stall_f), 32'(exp_stall));
      chk("stall_d", 32'(stall_d), 32'(exp_stall));
    end
    @(posedge clk);
    bubble = hazard || pc_src_e || !valid_d;
    if (rst) begin
      m_known = 1; m_full = 0; m_is_load = 0; m_rw = 0; m_mw = 0; m_br = 0; m_as = 0;
      m_alu = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pc4 = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    end else if (m_known && bubble) begin
      m_full = 0; m_is_load = 0; m_rw = 0; m_mw = 0; m_br = 0; m_rd = 0;
    end else if (m_known) begin
      m_full = 1; m_is_load = result_src_d; m_rw = reg_write_d; m_mw = mem_write_d;
      m_br = branch_d; m_as = alu_src_d; m_alu = alu_control_d;
      m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_ext_d; m_pc = pc_d; m_pc4 = pc_plus4_d;
      m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
    end
    #1;
    if (m_known) begin
      chk("valid_e", 32'(valid_e), 32'(m_full));
      chk("reg_write_e", 32'(reg_write_e), 32'(m_rw));
      chk("mem_write_e", 32'(mem_write_e), 32'(m_mw));
      chk("branch_e", 32'(branch_e), 32'(m_br));
      chk("result_src_e", 32'(result_src_e), 32'(m_is_load));
      chk("rd_e", 32'(rd_e), 32'(m_rd));
      if (m_full || rst) begin
        chk("alu_src_e", 32'(alu_src_e), 32'(m_as));
        chk("alu_control_e", 32'(alu_control_e), 32'(m_alu));
        chk("rd1_e", rd1_e, m_rd1);
        chk("rd2_e", rd2_e, m_rd2);
        chk("imm_ext_e", imm_ext_e, m_imm);
        chk("pc_e", pc_e, m_pc);
        chk("pc_plus4_e", pc_plus4_e, m_pc4);
        chk("rs1_e", 32'(rs1_e), 32'(m_rs1));
        chk("rs2_e", 32'(rs2_e), 32'(m_rs2));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with busy D inputs.
    rst = 1'b1;
    rand_d();
    valid_d = 1'b1;
    pc_src_e = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_valid", 32'(valid_e), 32'd0);
    chk("rst_pc", pc_e, 32'd0);
    rst = 1'b0;

    // add x3,x1,x2
    clear_d();
    valid_d = 1; reg_write_d = 1; rd1_d = 5; rd2_d = 7; rs1_d = 1; rs2_d = 2; rd_d = 3;
    pc_d = 32'h40; pc_plus4_d = 32'h44;
    cycle();
    chk("add_rd1", rd1_e, 32'd5);
    chk("add_pc4", pc_plus4_e, 32'h44);
    chk("add_valid", 32'(valid_e), 32'd1);

    // lw x5 then dependent add: one stall, bubble, then the add is captured.
    clear_d();
    valid_d = 1; reg_write_d = 1; result_src_d = 1; alu_src_d = 1; rs1_d = 2; rd_d = 5;
    cycle();
    clear_d();
    valid_d = 1; reg_write_d = 1; rs1_d = 5; rs2_d = 9; rd_d = 6;
    #1 chk("lu_stall", 32'(stall_f), 32'd1);
    cycle();
    chk("lu_bubble", 32'(valid_e), 32'd0);
    cycle();
    chk("lu_resume", 32'(valid_e), 32'd1);

    // lw x0 followed by a reader of x0, then lw x5 followed by independent add.
    clear_d();
    valid_d = 1; result_src_d = 1; rd_d = 0;
    cycle();
    clear_d();
    valid_d = 1; rs1_d = 0;
    cycle();
    clear_d();
    valid_d = 1; result_src_d = 1; rd_d = 5;
    cycle();
    clear_d();
    valid_d = 1; rs1_d = 6; rs2_d = 7; rd_d = 8;
    cycle();

    // Load-use coinciding with a taken branch.
    clear_d();
    valid_d = 1; result_src_d = 1; rd_d = 4;
    cycle();
    clear_d();
    valid_d = 1; mem_write_d = 1; branch_d = 1; rs2_d = 4; pc_src_e = 1;
    #1 chk("br_nostall", 32'(stall_f), 32'd0);
    cycle();

    // Reset asserted during a load-use stall.
    clear_d();
    valid_d = 1; result_src_d = 1; rd_d = 7;
    cycle();
    clear_d();
    valid_d = 1; rs1_d = 7; rst = 1;
    cycle();
    rst = 0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      rst = ($urandom_range(40) == 0);
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
